// File: rtl/level_ctrl_pkg.sv
// Shared types and sizing for the level controller and rf_stack.
// Both blocks must agree on NumLevels, LevelT and IrqIdT.
package level_ctrl_pkg;
  localparam int NumLevels = 4;
  localparam int NumIrqs   = 8;
  localparam int LevelW    = $clog2(NumLevels);
  localparam int IrqIdW    = $clog2(NumIrqs);

  typedef logic [LevelW-1:0] LevelT;
  typedef logic [IrqIdW-1:0] IrqIdT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2
  } state_t;

  // One preemption-stack frame: the context that was interrupted.
  typedef struct packed {
    LevelT level;
    IrqIdT irq;
  } frame_t;

  function automatic logic [NumIrqs-1:0] one_hot(IrqIdT idx);
    logic [NumIrqs-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/level_ctrl_if.sv
// Bus between the core/config side and the level controller.
// The master drives requests and configuration; the slave returns level and entry info.
interface level_ctrl_if;
  import level_ctrl_pkg::*;

  logic [NumIrqs-1:0] irqPend;
  logic               cfgWe;
  IrqIdT              cfgIdx;
  LevelT              cfgPrio;
  logic               cfgEn;
  logic               boundary;
  logic               retReq;

  LevelT              level;
  logic               writeRaEn;
  logic [NumIrqs-1:0] irqAck;
  IrqIdT              entryIrq;
  logic               retErr;

  modport master (
    output irqPend, cfgWe, cfgIdx, cfgPrio, cfgEn, boundary, retReq,
    input  level, writeRaEn, irqAck, entryIrq, retErr
  );

  modport slave (
    input  irqPend, cfgWe, cfgIdx, cfgPrio, cfgEn, boundary, retReq,
    output level, writeRaEn, irqAck, entryIrq, retErr
  );
endinterface

// File: rtl/level_ctrl_prio_arbiter.sv
// Combinational winner selection: highest prio strictly above the current level,
// lowest index on a tie.
module prio_arbiter
  import level_ctrl_pkg::LevelT, level_ctrl_pkg::IrqIdT;
#(
  parameter int NumIrqs = level_ctrl_pkg::NumIrqs
) (
  input  logic  [NumIrqs-1:0] pend,
  input  logic  [NumIrqs-1:0] en,
  input  LevelT [NumIrqs-1:0] prio,
  input  LevelT               level,
  output logic                valid,
  output IrqIdT               idx,
  output LevelT               win_prio
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid    = 1'b0;
    idx      = '0;
    win_prio = '0;
    for (int i = 0; i < NumIrqs; i++) begin
      // Strict '>' against the running best keeps the lowest index on a tie.
      if (pend[i] && en[i] && (prio[i] > level) && (!valid || (prio[i] > win_prio))) begin
        valid    = 1'b1;
        idx      = IrqIdT'(i);
        win_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/level_ctrl.sv
// Execution-level controller: arbitrates interrupts against the current level,
// stacks the preempted context on entry and restores it on handler return.
module level_ctrl
  import level_ctrl_pkg::LevelT, level_ctrl_pkg::IrqIdT, level_ctrl_pkg::state_t,
         level_ctrl_pkg::frame_t, level_ctrl_pkg::one_hot,
         level_ctrl_pkg::IDLE, level_ctrl_pkg::ENTER, level_ctrl_pkg::EXIT;
#(
  parameter int NumLevels = level_ctrl_pkg::NumLevels,
  parameter int NumIrqs   = level_ctrl_pkg::NumIrqs
) (
  input logic         clk,
  input logic         reset,
  level_ctrl_if.slave bus
);

  localparam int Depth = NumLevels - 1;
  localparam int SpW   = $clog2(NumLevels);
  typedef logic [SpW-1:0] sp_t;

  LevelT [NumIrqs-1:0] prio_q;
  logic  [NumIrqs-1:0] en_q;

  state_t state_q, state_d;
  LevelT  level_q, level_d;
  IrqIdT  cur_irq_q, cur_irq_d;
  sp_t    sp_q, sp_d;
  frame_t stack_q [Depth];
  logic   push;

  logic               wra_q, wra_d;
  logic [NumIrqs-1:0] ack_q, ack_d;
  IrqIdT              entry_q, entry_d;
  logic               ret_err_q, ret_err_d;

  logic  win_valid;
  IrqIdT win_idx;
  LevelT win_prio;

  prio_arbiter #(.NumIrqs(NumIrqs)) u_arb (
    .pend     (bus.irqPend),
    .en       (en_q),
    .prio     (prio_q),
    .level    (level_q),
    .valid    (win_valid),
    .idx      (win_idx),
    .win_prio (win_prio)
  );

  always_comb begin
    state_d   = IDLE;
    level_d   = level_q;
    cur_irq_d = cur_irq_q;
    sp_d      = sp_q;
    wra_d     = 1'b0;
    ack_d     = '0;
    entry_d   = entry_q;
    ret_err_d = 1'b0;
    push      = 1'b0;
    // ENTER and EXIT last one cycle and ignore boundary/retReq.
    if (state_q == IDLE) begin
      if (bus.retReq) begin
        if (level_q != '0) begin
          state_d   = EXIT;
          level_d   = stack_q[sp_q - sp_t'(1)].level;
          cur_irq_d = stack_q[sp_q - sp_t'(1)].irq;
          sp_d      = sp_q - sp_t'(1);
        end else begin
          ret_err_d = 1'b1;
        end
      end else if (bus.boundary && win_valid) begin
        state_d   = ENTER;
        push      = 1'b1;
        level_d   = win_prio;
        cur_irq_d = win_idx;
        sp_d      = sp_q + sp_t'(1);
        wra_d     = 1'b1;
        ack_d     = one_hot(win_idx);
        entry_d   = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      cur_irq_q <= '0;
      sp_q      <= '0;
      wra_q     <= 1'b0;
      ack_q     <= '0;
      entry_q   <= '0;
      ret_err_q <= 1'b0;
      prio_q    <= '0;
      en_q      <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cur_irq_q <= cur_irq_d;
      sp_q      <= sp_d;
      wra_q     <= wra_d;
      ack_q     <= ack_d;
      entry_q   <= entry_d;
      ret_err_q <= ret_err_d;
      if (bus.cfgWe) begin
        prio_q[bus.cfgIdx] <= bus.cfgPrio;
        en_q[bus.cfgIdx]   <= bus.cfgEn;
      end
    end
  end

  // NOTE: stack storage has no reset; entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= '{level: level_q, irq: cur_irq_q};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (sp_q == sp_t'(Depth))));

  assign bus.level     = level_q;
  assign bus.writeRaEn = wra_q;
  assign bus.irqAck    = ack_q;
  assign bus.entryIrq  = entry_q;
  assign bus.retErr    = ret_err_q;

endmodule
